// File: rtl/uart_tx_feeder.sv
// FIFO-buffered feeder for the UART transmitter: queues producer words and hands
// them over one at a time on the ld_tx_data/tx_busy handshake, with an inter-frame gap.
module uart_tx_feeder #(
   parameter int WIDTH       = 18,
   parameter int DEPTH       = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                       txclk,
   input  logic                       reset_n,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic                       flush,
   input  logic                       tx_busy,
   output logic                       ld_tx_data,
   output logic [WIDTH-1:0]           tx_data,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       ack_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ld_q, ld_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ack_err_q, ack_err_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push;
   logic             pop;

   assign wr_ready   = (count_q < CW'(DEPTH));
   assign push       = wr_valid && wr_ready && !flush;
   assign ld_tx_data = ld_q;
   assign tx_data    = data_q;
   assign fifo_count = count_q;
   assign ack_err    = ack_err_q;

   // A flush in the same cycle suppresses the pop so no discarded word is ever issued.
   always_comb begin
      state_d   = state_q;
      ld_d      = 1'b0;
      data_d    = data_q;
      ack_err_d = ack_err_q;
      timer_d   = timer_q;
      gap_cnt_d = gap_cnt_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0 && !tx_busy && !flush) begin
               pop     = 1'b1;
               ld_d    = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               state_d = LOAD;
            end
         end
         LOAD: begin
            timer_d = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
               ack_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge txclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ld_q      <= 1'b0;
         data_q    <= '0;
         ack_err_q <= 1'b0;
         timer_q   <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ld_q      <= ld_d;
         data_q    <= data_d;
         ack_err_q <= ack_err_d;
         timer_q   <= timer_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge txclk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder: a transaction-level reference model (word queue
// plus edge timestamps) predicts every output; a simple transmitter model drives tx_busy.
module tb_uart_tx_feeder;

   localparam int WIDTH       = 18;
   localparam int DEPTH       = 8;
   localparam int GAP_CYCLES  = 2;
   localparam int ACK_TIMEOUT = 4;
   localparam int FRAME       = 20;
   localparam int CW          = $clog2(DEPTH + 1);

   logic             txclk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic             flush;
   logic             tx_busy;
   logic             ld_tx_data;
   logic [WIDTH-1:0] tx_data;
   logic [CW-1:0]    fifo_count;
   logic             ack_err;

   uart_tx_feeder #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .txclk(txclk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .flush(flush), .tx_busy(tx_busy), .ld_tx_data(ld_tx_data),
      .tx_data(tx_data), .fifo_count(fifo_count), .ack_err(ack_err)
   );

   always #5 txclk = ~txclk;

   int errors = 0;
   int checks = 0;

   // Reference model: queued words plus timestamps of the word in flight.
   logic [WIDTH-1:0] mq[$];
   int               edge_no = 0;
   bit               m_inflight, m_acked, m_ld, m_ack_err;
   int               m_load_edge, m_next_pop;
   logic [WIDTH-1:0] m_data;

   // Transmitter model state.
   int busy_left  = 0;
   bit tx_pending = 0;
   bit ack_mode   = 1;
   bit force_busy = 0;
   int ld_seen    = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      m_inflight = 0;
      m_acked    = 0;
      m_ld       = 0;
      m_ack_err  = 0;
      m_data     = '0;
      m_next_pop = 0;
      m_load_edge = 0;
   endtask

   // One clock edge of the reference model, using the inputs applied before the edge.
   task automatic modelEdge();
      bit               pop, push, busy;
      logic [WIDTH-1:0] w;
      edge_no++;
      busy = tx_busy;
      pop  = !m_inflight && (edge_no >= m_next_pop) && (mq.size() > 0) && !busy && !flush;
      push = wr_valid && (mq.size() < DEPTH) && !flush;
      m_ld = 0;
      if (m_inflight) begin
         if (m_acked) begin
            if (!busy) begin
               m_inflight = 0;
               m_next_pop = edge_no + GAP_CYCLES + 1;
            end
         end else if (edge_no >= m_load_edge + 2) begin
            if (busy) m_acked = 1;
            else if (edge_no == m_load_edge + 1 + ACK_TIMEOUT) begin
               m_ack_err  = 1;
               m_inflight = 0;
               m_next_pop = edge_no + 1;
            end
         end
      end
      if (flush) mq.delete();
      if (pop) begin
         w           = mq.pop_front();
         m_data      = w;
         m_ld        = 1;
         m_inflight  = 1;
         m_acked     = 0;
         m_load_edge = edge_no;
      end
      if (push) mq.push_back(wr_data);
   endtask

   task automatic compareAll();
      checkOutput("ld_tx_data", 32'(ld_tx_data), 32'(m_ld));
      checkOutput("tx_data",    32'(tx_data),    32'(m_data));
      checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
      checkOutput("wr_ready",   32'(wr_ready),   32'(mq.size() < DEPTH));
      checkOutput("ack_err",    32'(ack_err),    32'(m_ack_err));
   endtask

   // Called just after a negedge: drive one cycle of inputs, clock it, check at next negedge.
   task automatic applyStimulus(input bit valid, input logic [WIDTH-1:0] data, input bit fl);
      if (tx_pending) begin
         if (ack_mode) busy_left = FRAME;
         tx_pending = 0;
      end
      tx_busy  = force_busy || (busy_left > 0);
      if (busy_left > 0) busy_left--;
      wr_valid = valid;
      wr_data  = data;
      flush    = fl;
      @(posedge txclk);
      if (reset_n) modelEdge();
      @(negedge txclk);
      compareAll();
      if (ld_tx_data === 1'b1) begin
         tx_pending = 1;
         ld_seen++;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, 0);
   endtask

   task automatic randomCycles(input int n, input int push_pct, input int flush_pct);
      for (int i = 0; i < n; i++)
         applyStimulus($urandom_range(0, 99) < push_pct, WIDTH'($urandom),
                       $urandom_range(0, 99) < flush_pct);
   endtask

   initial begin
      #(10 * 60000);
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit done;
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      flush    = 1'b0;
      tx_busy  = 1'b0;
      modelReset();
      @(negedge txclk);
      compareAll();
      reset_n = 1'b1;

      $display("[TB] single word latency");
      applyStimulus(1, 18'h2A5A5, 0);
      checkOutput("lat_edge1_ld", 32'(ld_tx_data), 32'd0);
      applyStimulus(0, '0, 0);
      checkOutput("lat_edge2_ld", 32'(ld_tx_data), 32'd1);
      checkOutput("lat_edge2_data", 32'(tx_data), 32'h2A5A5);
      idleCycles(40);
      checkOutput("single_data_hold", 32'(tx_data), 32'h2A5A5);

      $display("[TB] burst into busy transmitter");
      randomCycles(30, 100, 0);
      idleCycles(300);

      $display("[TB] random traffic");
      randomCycles(500, 35, 2);
      idleCycles(300);

      $display("[TB] flush with one in flight");
      for (int i = 0; i < 6; i++) applyStimulus(1, WIDTH'($urandom), 0);
      checkOutput("preflush_count", 32'(fifo_count), 32'd5);
      ld_seen = 0;
      applyStimulus(1, WIDTH'($urandom), 1);
      checkOutput("flush_count", 32'(fifo_count), 32'd0);
      idleCycles(60);
      checkOutput("flush_no_load", 32'(ld_seen), 32'd0);

      $display("[TB] unsolicited busy blocks loads");
      force_busy = 1;
      ld_seen = 0;
      for (int i = 0; i < 3; i++) applyStimulus(1, WIDTH'($urandom), 0);
      idleCycles(20);
      checkOutput("forced_busy_no_load", 32'(ld_seen), 32'd0);
      checkOutput("forced_busy_count", 32'(fifo_count), 32'd3);
      force_busy = 0;
      idleCycles(150);
      checkOutput("forced_busy_drained", 32'(ld_seen), 32'd3);

      $display("[TB] transmitter never acknowledges");
      ack_mode = 0;
      ld_seen = 0;
      for (int i = 0; i < 3; i++) applyStimulus(1, WIDTH'($urandom), 0);
      idleCycles(40);
      checkOutput("noack_err", 32'(ack_err), 32'd1);
      checkOutput("noack_loads", 32'(ld_seen), 32'd3);
      ack_mode = 1;
      randomCycles(200, 30, 0);
      idleCycles(300);

      $display("[TB] reset during frame");
      for (int i = 0; i < 4; i++) applyStimulus(1, WIDTH'($urandom), 0);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (m_inflight && m_acked && mq.size() == 3) done = 1;
         else applyStimulus(0, '0, 0);
      end
      checkOutput("reach_wait_done", 32'(done), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_ld",    32'(ld_tx_data), 32'd0);
      checkOutput("rst_data",  32'(tx_data),    32'd0);
      checkOutput("rst_count", 32'(fifo_count), 32'd0);
      checkOutput("rst_ready", 32'(wr_ready),   32'd1);
      checkOutput("rst_ack",   32'(ack_err),    32'd0);
      modelReset();
      idleCycles(2);
      reset_n = 1'b1;
      ld_seen = 0;
      idleCycles(40);
      checkOutput("post_reset_no_load", 32'(ld_seen), 32'd0);
      randomCycles(300, 40, 3);
      idleCycles(300);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
